// File: rtl/pipe_ctrl.sv
// Pipeline control responder: turns load-use, branch-redirect and memory-wait
// requests into per-stage write/flush controls, with a watchdog and perf counters.
module pipe_ctrl #(
  parameter int FLUSH_EXTRA = 0,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic             MEM_MemAccess,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] FreezeCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         fcnt_reg, fcnt_next;
  logic [WAIT_W-1:0]  wait_reg;
  logic               timeout_reg;
  logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg, freeze_cnt_reg;
  logic               freeze, stall_ev, flush_ev;

  assign freeze = MEM_MemAccess & ~MemReady;

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    state_next   = state_reg;
    fcnt_next    = fcnt_reg;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;
    if (rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
      state_next   = RUN;
      fcnt_next    = '0;
    end else if (freeze) begin
      // Whole pipe holds; only a bubble drains into WB. FSM state is frozen too.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      flush_ev    = 1'b1;
      if (FLUSH_EXTRA > 0) begin
        fcnt_next  = 4'(FLUSH_EXTRA);
        state_next = FLUSH;
      end else begin
        fcnt_next  = '0;
        state_next = RUN;
      end
    end else if (state_reg == FLUSH) begin
      IF_ID_Flush = 1'b1;
      fcnt_next   = fcnt_reg - 4'd1;
      if (fcnt_reg <= 4'd1) begin
        state_next = RUN;
        fcnt_next  = '0;
      end
    end else if (Stall) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      stall_ev    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      fcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  // Watchdog counts consecutive freeze cycles; saturates at the threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else if (freeze) begin
      if (wait_reg != WAIT_W'(MEM_TIMEOUT))
        wait_reg <= wait_reg + 1'b1;
      if (wait_reg >= WAIT_W'(MEM_TIMEOUT - 1))
        timeout_reg <= 1'b1;
    end else begin
      wait_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
    end else begin
      if (stall_ev && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_ev && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      if (freeze && freeze_cnt_reg != '1)
        freeze_cnt_reg <= freeze_cnt_reg + 1'b1;
    end
  end

  assign MemTimeout = timeout_reg;
  assign StallCnt   = stall_cnt_reg;
  assign FlushCnt   = flush_cnt_reg;
  assign FreezeCnt  = freeze_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (FLUSH_EXTRA=2, MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_ctrl;

  logic       clk, rst, Stall, BranchTaken, MEM_MemAccess, MemReady;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic       EX_MEM_Write, MEM_WB_Flush, MemTimeout;
  logic [3:0] StallCnt, FlushCnt, FreezeCnt;
  logic [6:0] ctrl;
  int         checks = 0;
  int         failures = 0;

  // ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush}
  localparam logic [6:0] C_RST    = 7'b0010101;
  localparam logic [6:0] C_DEF    = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_FLUSH  = 7'b1111010;

  pipe_ctrl #(.FLUSH_EXTRA(2), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .BranchTaken(BranchTaken),
    .MEM_MemAccess(MEM_MemAccess), .MemReady(MemReady),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Flush(MEM_WB_Flush),
    .MemTimeout(MemTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt),
    .FreezeCnt(FreezeCnt)
  );

  assign ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                 EX_MEM_Write, MEM_WB_Flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, settle, then let the caller check.
  task automatic step(input logic s, input logic b, input logic ma, input logic mr);
    @(negedge clk);
    Stall = s; BranchTaken = b; MEM_MemAccess = ma; MemReady = mr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; Stall = 0; BranchTaken = 0; MEM_MemAccess = 0; MemReady = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Stall = 1; BranchTaken = 1; MEM_MemAccess = 0; MemReady = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (ctrl !== C_RST) begin
        failures++; $display("FAIL reset_ctrl cyc%0d got=%b exp=%b", i, ctrl, C_RST);
      end
    end
    @(negedge clk);
    rst = 1'b0; Stall = 0; BranchTaken = 0;
    #1;
    checks++;
    if (ctrl !== C_DEF) begin
      failures++; $display("FAIL reset_release_ctrl got=%b exp=%b", ctrl, C_DEF);
    end
    checks++;
    if ({StallCnt, FlushCnt, FreezeCnt, MemTimeout} !== 13'd0) begin
      failures++; $display("FAIL reset_counters got=%h/%h/%h/%b exp=0/0/0/0",
                           StallCnt, FlushCnt, FreezeCnt, MemTimeout);
    end
    $display("reset: done");
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0);
    checks++;
    if (ctrl !== C_STALL) begin
      failures++; $display("FAIL stall_ctrl got=%b exp=%b", ctrl, C_STALL);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ctrl !== C_DEF) begin
      failures++; $display("FAIL stall_after_ctrl got=%b exp=%b", ctrl, C_DEF);
    end
    checks++;
    if (StallCnt !== 4'd1) begin
      failures++; $display("FAIL stall_cnt got=%0d exp=1", StallCnt);
    end
    $display("stall: single load-use cycle");
  endtask

  task automatic test_branch_stall();
    do_reset();
    step(1, 1, 0, 0);
    checks++;
    if (ctrl !== C_BRANCH) begin
      failures++; $display("FAIL br_stall_ctrl got=%b exp=%b", ctrl, C_BRANCH);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (ctrl !== C_FLUSH) begin
        failures++; $display("FAIL br_flush_ctrl cyc%0d got=%b exp=%b", i, ctrl, C_FLUSH);
      end
    end
    checks++;
    if (StallCnt !== 4'd0 || FlushCnt !== 4'd1) begin
      failures++; $display("FAIL br_counts got=%0d/%0d exp=0/1", StallCnt, FlushCnt);
    end
    step(1, 0, 0, 0);
    checks++;
    if (ctrl !== C_STALL) begin
      failures++; $display("FAIL br_back_to_run got=%b exp=%b", ctrl, C_STALL);
    end
    step(0, 0, 0, 0);
    $display("branch+stall: redirect wins, 2 extra bubbles");
  endtask

  task automatic test_freeze_in_flush();
    do_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0);
      checks++;
      if (ctrl !== C_FREEZE || FreezeCnt !== 4'(i)) begin
        failures++; $display("FAIL freeze_ctrl cyc%0d got=%b/%0d exp=%b/%0d",
                             i, ctrl, FreezeCnt, C_FREEZE, i);
      end
    end
    step(0, 0, 1, 1);
    checks++;
    if (ctrl !== C_FLUSH || FreezeCnt !== 4'd5 || FlushCnt !== 4'd1) begin
      failures++; $display("FAIL freeze_resume got=%b/%0d/%0d exp=%b/5/1",
                           ctrl, FreezeCnt, FlushCnt, C_FLUSH);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ctrl !== C_FLUSH) begin
      failures++; $display("FAIL freeze_flush2 got=%b exp=%b", ctrl, C_FLUSH);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ctrl !== C_DEF) begin
      failures++; $display("FAIL freeze_run got=%b exp=%b", ctrl, C_DEF);
    end
    $display("freeze: 5 cycles inside FLUSH");
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, 0);
      checks++;
      if (MemTimeout !== (i >= 4)) begin
        failures++; $display("FAIL timeout_rise cyc%0d got=%b exp=%b", i, MemTimeout, (i >= 4));
      end
    end
    step(0, 0, 1, 1);
    checks++;
    if (MemTimeout !== 1'b1 || FreezeCnt !== 4'd6 || StallCnt !== 4'd0) begin
      failures++; $display("FAIL timeout_hold got=%b/%0d/%0d exp=1/6/0",
                           MemTimeout, FreezeCnt, StallCnt);
    end
    step(0, 0, 0, 0);
    checks++;
    if (MemTimeout !== 1'b1 || ctrl !== C_DEF) begin
      failures++; $display("FAIL timeout_sticky got=%b/%b exp=1/%b", MemTimeout, ctrl, C_DEF);
    end
    do_reset();
    #1;
    checks++;
    if (MemTimeout !== 1'b0) begin
      failures++; $display("FAIL timeout_clear got=%b exp=0", MemTimeout);
    end
    $display("timeout: watchdog after 4 freeze cycles");
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (ctrl !== C_BRANCH) begin
      failures++; $display("FAIL b2b_ctrl got=%b exp=%b", ctrl, C_BRANCH);
    end
    step(0, 0, 0, 0);
    checks++;
    if (ctrl !== C_FLUSH || FlushCnt !== 4'd2) begin
      failures++; $display("FAIL b2b_flush got=%b/%0d exp=%b/2", ctrl, FlushCnt, C_FLUSH);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (ctrl !== C_DEF) begin
      failures++; $display("FAIL b2b_run got=%b exp=%b", ctrl, C_DEF);
    end
    $display("back_to_back: redirect in FLUSH reloads");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (StallCnt !== 4'((i < 15) ? i : 15)) begin
        failures++; $display("FAIL sat_cnt cyc%0d got=%0d exp=%0d", i, StallCnt, (i < 15) ? i : 15);
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (StallCnt !== 4'd15) begin
      failures++; $display("FAIL sat_final got=%0d exp=15", StallCnt);
    end
    $display("saturate: StallCnt pinned at 15");
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch_stall();
    test_freeze_in_flush();
    test_timeout();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
